// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit for a 5-stage RV32I pipeline.
// Produces the forwarding selects, the stage load/bubble controls and the
// cache-request gating. It also keeps stall and flush performance counters.
// Control outputs are decoded combinationally from the current stage contents
// and the miss-tracking flags, so the datapath sees them in the same cycle.
module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic [4:0]           ex_rs1,
    input  logic [4:0]           ex_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_load_regfile,
    input  logic                 ex_dcache_read,
    input  logic [4:0]           mem_rd,
    input  logic                 mem_load_regfile,
    input  logic [4:0]           wb_rd,
    input  logic                 wb_load_regfile,
    input  logic                 br_taken,
    input  logic                 icache_read,
    input  logic                 icache_resp,
    input  logic                 dcache_req,
    input  logic                 dcache_resp,
    output logic                 icache_read_gated,
    output logic                 dcache_req_gated,
    output logic [1:0]           rs1mux_sel,
    output logic [1:0]           rs2mux_sel,
    output logic                 pc_load,
    output logic                 pipe_load_ifid,
    output logic                 pipe_load_idex,
    output logic                 pipe_load_exmem,
    output logic                 pipe_load_memwb,
    output logic                 pipe_rst_ifid,
    output logic                 pipe_rst_idex,
    output logic                 pipe_rst_exmem,
    output logic                 pipe_rst_memwb,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic                   i_done_q, i_done_d;
    logic                   d_done_q, d_done_d;
    logic [CNT_WIDTH-1:0]   stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0]   flush_count_q, flush_count_d;

    logic                   i_done_s;
    logic                   d_done_s;
    logic                   imiss_s;
    logic                   dmiss_s;
    logic                   freeze_s;
    logic                   load_use_s;
    logic                   release_s;
    logic                   stall_inc_s;
    logic                   flush_inc_s;

    // Forwarding select for one EX source: the younger EX/MEM result beats MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_ld,
        input logic [4:0] w_rd,
        input logic       w_ld
    );
        logic [1:0] sel;
        if (m_ld && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b01;
        end else if (w_ld && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Done flags are treated as clear while reset is held so requests re-issue at once.
    always_comb begin
        i_done_s   = i_done_q & ~rst;
        d_done_s   = d_done_q & ~rst;
        imiss_s    = icache_read & ~icache_resp & ~i_done_s;
        dmiss_s    = dcache_req & ~dcache_resp & ~d_done_s;
        freeze_s   = imiss_s | dmiss_s;
        release_s  = (state_q == MISS_WAIT) & ~freeze_s;
        load_use_s = ex_dcache_read & ex_load_regfile & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        icache_read_gated = icache_read & ~i_done_s;
        dcache_req_gated  = dcache_req & ~d_done_s;
    end

    // Forwarding selects, forced to the ID/EX value during reset.
    always_comb begin
        rs1mux_sel = 2'b00;
        rs2mux_sel = 2'b00;
        if (rst) begin
            rs1mux_sel = 2'b00;
            rs2mux_sel = 2'b00;
        end else begin
            rs1mux_sel = fwd_sel(ex_rs1, mem_rd, mem_load_regfile, wb_rd, wb_load_regfile);
            rs2mux_sel = fwd_sel(ex_rs2, mem_rd, mem_load_regfile, wb_rd, wb_load_regfile);
        end
    end

    // Pipeline-control decode: reset, freeze, branch flush, load-use bubble, normal advance.
    always_comb begin
        pc_load         = 1'b0;
        pipe_load_ifid  = 1'b0;
        pipe_load_idex  = 1'b0;
        pipe_load_exmem = 1'b0;
        pipe_load_memwb = 1'b0;
        pipe_rst_ifid   = 1'b0;
        pipe_rst_idex   = 1'b0;
        pipe_rst_exmem  = 1'b0;
        pipe_rst_memwb  = 1'b0;
        stall_inc_s     = 1'b0;
        flush_inc_s     = 1'b0;
        if (rst) begin
            pipe_rst_ifid  = 1'b1;
            pipe_rst_idex  = 1'b1;
            pipe_rst_exmem = 1'b1;
            pipe_rst_memwb = 1'b1;
        end else if (freeze_s) begin
            // Whole pipe holds; a pending branch stays in EX and is taken on release.
            stall_inc_s = 1'b1;
        end else if (br_taken) begin
            pc_load         = 1'b1;
            pipe_load_ifid  = 1'b1;
            pipe_load_idex  = 1'b1;
            pipe_load_exmem = 1'b1;
            pipe_load_memwb = 1'b1;
            pipe_rst_ifid   = 1'b1;
            pipe_rst_idex   = 1'b1;
            flush_inc_s     = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and IF/ID, squash ID/EX to a bubble, let the load move on.
            pipe_load_idex  = 1'b1;
            pipe_load_exmem = 1'b1;
            pipe_load_memwb = 1'b1;
            pipe_rst_idex   = 1'b1;
            stall_inc_s     = 1'b1;
        end else begin
            pc_load         = 1'b1;
            pipe_load_ifid  = 1'b1;
            pipe_load_idex  = 1'b1;
            pipe_load_exmem = 1'b1;
            pipe_load_memwb = 1'b1;
        end
    end

    // Next-state logic for the miss FSM, done flags and counters.
    always_comb begin
        state_d       = state_q;
        i_done_d      = i_done_q;
        d_done_d      = d_done_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (rst) begin
            state_d       = RUN;
            i_done_d      = 1'b0;
            d_done_d      = 1'b0;
            stall_count_d = {CNT_WIDTH{1'b0}};
            flush_count_d = {CNT_WIDTH{1'b0}};
        end else begin
            case (state_q)
                RUN:       state_d = freeze_s ? MISS_WAIT : RUN;
                MISS_WAIT: state_d = freeze_s ? MISS_WAIT : RUN;
                default:   state_d = RUN;
            endcase
            if (freeze_s) begin
                // Remember a response that arrived while the other cache still misses.
                i_done_d = i_done_q | icache_resp;
                d_done_d = d_done_q | dcache_resp;
            end else if (release_s) begin
                i_done_d = 1'b0;
                d_done_d = 1'b0;
            end else begin
                i_done_d = i_done_q;
                d_done_d = d_done_q;
            end
            if (stall_inc_s) begin
                stall_count_d = stall_count_q + CNT_ONE;
            end else begin
                stall_count_d = stall_count_q;
            end
            if (flush_inc_s) begin
                flush_count_d = flush_count_q + CNT_ONE;
            end else begin
                flush_count_d = flush_count_q;
            end
        end
    end

    // State, flag and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            stall_count_q <= {CNT_WIDTH{1'b0}};
            flush_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            i_done_q      <= i_done_d;
            d_done_q      <= d_done_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl. Expected values are
// pushed to a scoreboard queue when each step's inputs are driven and popped
// and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_load_regfile, ex_dcache_read, mem_load_regfile, wb_load_regfile;
    logic        br_taken, icache_read, icache_resp, dcache_req, dcache_resp;
    logic        icache_read_gated, dcache_req_gated;
    logic [1:0]  rs1mux_sel, rs2mux_sel;
    logic        pc_load;
    logic        pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb;
    logic        pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb;
    logic [31:0] stall_count, flush_count;

    pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_load_regfile(ex_load_regfile), .ex_dcache_read(ex_dcache_read),
        .mem_rd(mem_rd), .mem_load_regfile(mem_load_regfile),
        .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile),
        .br_taken(br_taken), .icache_read(icache_read), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp),
        .icache_read_gated(icache_read_gated), .dcache_req_gated(dcache_req_gated),
        .rs1mux_sel(rs1mux_sel), .rs2mux_sel(rs2mux_sel), .pc_load(pc_load),
        .pipe_load_ifid(pipe_load_ifid), .pipe_load_idex(pipe_load_idex),
        .pipe_load_exmem(pipe_load_exmem), .pipe_load_memwb(pipe_load_memwb),
        .pipe_rst_ifid(pipe_rst_ifid), .pipe_rst_idex(pipe_rst_idex),
        .pipe_rst_exmem(pipe_rst_exmem), .pipe_rst_memwb(pipe_rst_memwb),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pipe = {pc_load, load ifid/idex/exmem/memwb, rst ifid/idex/exmem/memwb}
    localparam logic [8:0] P_NORM = 9'b1_1111_0000;
    localparam logic [8:0] P_FRZ  = 9'b0_0000_0000;
    localparam logic [8:0] P_RST  = 9'b0_0000_1111;
    localparam logic [8:0] P_BUB  = 9'b0_0111_0100;
    localparam logic [8:0] P_BR   = 9'b1_1111_1100;

    typedef struct {
        string       tag;
        logic [14:0] ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          failures;
    logic [14:0] obs_ctrl;

    assign obs_ctrl = {icache_read_gated, dcache_req_gated, rs1mux_sel, rs2mux_sel,
                       pc_load, pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
                       pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb};

    // Advance to just after the next rising edge and return all inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        ex_load_regfile = 1'b0; ex_dcache_read = 1'b0;
        mem_load_regfile = 1'b0; wb_load_regfile = 1'b0;
        br_taken = 1'b0; icache_read = 1'b0; icache_resp = 1'b0;
        dcache_req = 1'b0; dcache_resp = 1'b0;
    endtask

    // Push the expectation for the inputs just driven, then pop and compare at the falling edge.
    task automatic step(input string tag, input logic icg, input logic dcg,
                        input logic [1:0] s1, input logic [1:0] s2, input logic [8:0] pipe,
                        input int stall, input int flush);
        exp_t e;
        e.tag   = tag;
        e.ctrl  = {icg, dcg, s1, s2, pipe};
        e.stall = stall;
        e.flush = flush;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (obs_ctrl === e.ctrl) else begin
            failures++;
            $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs_ctrl, e.ctrl);
        end
        checks++;
        assert (stall_count === e.stall) else begin
            failures++;
            $error("FAIL %s stall_count observed=%0d expected=%0d", e.tag, stall_count, e.stall);
        end
        checks++;
        assert (flush_count === e.flush) else begin
            failures++;
            $error("FAIL %s flush_count observed=%0d expected=%0d", e.tag, flush_count, e.flush);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b1;
        step("reset", 1'b0, 1'b0, 2'b00, 2'b00, P_RST, 0, 0);

        // Forwarding: EX/MEM beats MEM/WB, then MEM/WB alone, then x0 never forwards.
        tick();
        mem_rd = 5'd5; mem_load_regfile = 1'b1; ex_rs1 = 5'd5; wb_rd = 5'd5; wb_load_regfile = 1'b1;
        step("fwd_mem_prio", 1'b0, 1'b0, 2'b01, 2'b00, P_NORM, 0, 0);
        tick();
        mem_rd = 5'd5; mem_load_regfile = 1'b0; ex_rs1 = 5'd5; ex_rs2 = 5'd5;
        wb_rd = 5'd5; wb_load_regfile = 1'b1;
        step("fwd_wb", 1'b0, 1'b0, 2'b10, 2'b10, P_NORM, 0, 0);
        tick();
        mem_rd = 5'd0; mem_load_regfile = 1'b1; wb_rd = 5'd0; wb_load_regfile = 1'b1;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        step("fwd_x0", 1'b0, 1'b0, 2'b00, 2'b00, P_NORM, 0, 0);
        tick();
        mem_rd = 5'd9; mem_load_regfile = 1'b1; wb_rd = 5'd4; wb_load_regfile = 1'b1;
        ex_rs1 = 5'd4; ex_rs2 = 5'd9;
        step("fwd_split", 1'b0, 1'b0, 2'b10, 2'b01, P_NORM, 0, 0);

        // Load-use: one bubble, then the consumer forwards from WB.
        tick();
        ex_dcache_read = 1'b1; ex_load_regfile = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
        step("load_use", 1'b0, 1'b0, 2'b00, 2'b00, P_BUB, 0, 0);
        tick();
        mem_rd = 5'd7; mem_load_regfile = 1'b1; id_rs2 = 5'd7;
        step("after_bubble", 1'b0, 1'b0, 2'b00, 2'b00, P_NORM, 1, 0);
        tick();
        wb_rd = 5'd7; wb_load_regfile = 1'b1; ex_rs2 = 5'd7;
        step("load_fwd_wb", 1'b0, 1'b0, 2'b00, 2'b10, P_NORM, 1, 0);

        // Taken branch wins over a simultaneous load-use hazard.
        tick();
        ex_dcache_read = 1'b1; ex_load_regfile = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; br_taken = 1'b1;
        step("branch", 1'b0, 1'b0, 2'b00, 2'b00, P_BR, 1, 0);
        tick();
        step("post_branch", 1'b0, 1'b0, 2'b00, 2'b00, P_NORM, 1, 1);

        // Overlapped misses: icache responds at cycle 3, dcache at cycle 6.
        for (int c = 0; c < 6; c++) begin
            tick();
            icache_read = 1'b1; dcache_req = 1'b1;
            icache_resp = (c == 3) ? 1'b1 : 1'b0;
            step("miss_frozen", (c <= 3) ? 1'b1 : 1'b0, 1'b1, 2'b00, 2'b00, P_FRZ, 1 + c, 1);
        end
        tick();
        icache_read = 1'b1; dcache_req = 1'b1; dcache_resp = 1'b1;
        step("miss_release", 1'b0, 1'b1, 2'b00, 2'b00, P_NORM, 7, 1);
        tick();
        icache_read = 1'b1; icache_resp = 1'b1;
        step("i_done_cleared", 1'b1, 1'b0, 2'b00, 2'b00, P_NORM, 7, 1);

        // Simultaneous responses on the first miss cycle: no flag, no stall.
        tick();
        icache_read = 1'b1; dcache_req = 1'b1; icache_resp = 1'b1; dcache_resp = 1'b1;
        step("both_resp", 1'b1, 1'b1, 2'b00, 2'b00, P_NORM, 7, 1);
        tick();
        icache_read = 1'b1; dcache_req = 1'b1; icache_resp = 1'b1; dcache_resp = 1'b1;
        step("no_flag_set", 1'b1, 1'b1, 2'b00, 2'b00, P_NORM, 7, 1);

        // Reset during a dcache miss with d_done set.
        tick();
        dcache_req = 1'b1;
        step("dmiss", 1'b0, 1'b1, 2'b00, 2'b00, P_FRZ, 7, 1);
        tick();
        dcache_req = 1'b1; dcache_resp = 1'b1; icache_read = 1'b1;
        step("dresp_imiss", 1'b1, 1'b1, 2'b00, 2'b00, P_FRZ, 8, 1);
        tick();
        dcache_req = 1'b1; icache_read = 1'b1;
        step("d_done_held", 1'b1, 1'b0, 2'b00, 2'b00, P_FRZ, 9, 1);
        tick();
        rst = 1'b1; dcache_req = 1'b1; icache_read = 1'b1;
        mem_rd = 5'd2; mem_load_regfile = 1'b1; ex_rs1 = 5'd2;
        step("mid_miss_rst", 1'b1, 1'b1, 2'b00, 2'b00, P_RST, 10, 1);
        tick();
        dcache_req = 1'b1;
        step("after_rst", 1'b0, 1'b1, 2'b00, 2'b00, P_FRZ, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
